mem_port_arbiter: RTL

Two-requester arbiter for the single-port data/instruction memory. It shares the memory between the CPU core and an auxiliary master (I/O or display fetch engine), issuing at most one memory access per cycle with round-robin fairness. It returns synchronous-read data to the owning requester one cycle later. It sits between the CPU's memory interface and the block RAM.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/rr_pick2.sv | 17 +
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter: owner encoding and default widths.
package mem_arb_pkg;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_AUX = 1'b1;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AW    = 16;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker: a lone requester wins; on a tie the one that
// was not the last owner wins. Index 0 is the CPU, index 1 the auxiliary master.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | (last == OWN_AUX));
        gnt[1] = req[1] & (~req[0] | (last == OWN_CPU));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between the CPU and an auxiliary
// master with zero-latency round-robin grants and a one-cycle read return tag.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_rvalid,
    output logic [WIDTH-1:0] cpu_rdata,

    input  logic             aux_req,
    input  logic             aux_we,
    input  logic [AW-1:0]    aux_addr,
    input  logic [WIDTH-1:0] aux_wdata,
    output logic             aux_gnt,
    output logic             aux_rvalid,
    output logic [WIDTH-1:0] aux_rdata,

    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,

    output logic [CNT_W-1:0] cpu_stall_cnt,
    output logic [CNT_W-1:0] aux_stall_cnt
);

    logic             last_owner_reg;
    logic             last_owner_next;
    logic             rd_pending_reg;
    logic             rd_pending_next;
    logic             rd_owner_reg;
    logic             rd_owner_next;
    logic [1:0]       req_raw;
    logic [1:0]       req_vec;
    logic [1:0]       gnt_vec;
    logic [CNT_W-1:0] stall_cnt [2];

    assign req_raw = {aux_req, cpu_req};
    // Gating the picker inputs keeps every grant, and thus mem_en, low during reset.
    assign req_vec = req_raw & {2{~reset}};

    rr_pick2 u_pick (
        .req  (req_vec),
        .last (last_owner_reg),
        .gnt  (gnt_vec)
    );

    assign cpu_gnt = gnt_vec[0];
    assign aux_gnt = gnt_vec[1];

    always_comb begin
        mem_en          = cpu_gnt | aux_gnt;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        last_owner_next = last_owner_reg;
        if (cpu_gnt) begin
            mem_we          = cpu_we;
            mem_addr        = cpu_addr;
            mem_wdata       = cpu_wdata;
            last_owner_next = OWN_CPU;
        end else if (aux_gnt) begin
            mem_we          = aux_we;
            mem_addr        = aux_addr;
            mem_wdata       = aux_wdata;
            last_owner_next = OWN_AUX;
        end
        rd_pending_next = mem_en & ~mem_we;
        rd_owner_next   = aux_gnt ? OWN_AUX : OWN_CPU;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_reg <= OWN_AUX;
            rd_pending_reg <= 1'b0;
            rd_owner_reg   <= OWN_CPU;
        end else begin
            last_owner_reg <= last_owner_next;
            rd_pending_reg <= rd_pending_next;
            rd_owner_reg   <= rd_owner_next;
        end
    end

    assign cpu_rvalid = rd_pending_reg & (rd_owner_reg == OWN_CPU);
    assign aux_rvalid = rd_pending_reg & (rd_owner_reg == OWN_AUX);
    assign cpu_rdata  = mem_rdata;
    assign aux_rdata  = mem_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_stall
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            // Counts cycles spent waiting; holds at all-ones instead of wrapping.
            always_comb begin
                cnt_next = cnt_reg;
                if (req_raw[gi] && !gnt_vec[gi] && !(&cnt_reg)) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign stall_cnt[gi] = cnt_reg;
        end
    endgenerate

    assign cpu_stall_cnt = stall_cnt[0];
    assign aux_stall_cnt = stall_cnt[1];

endmodule
